// File: rtl/sdram_multi_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_multi_arbiter : shares one SDRAM command/data bus among an init
// sequencer, a refresh engine and NUM_CH client channels.   rev 1.0
// ---------------------------------------------------------------------------
module sdram_multi_arbiter #(
  parameter int NUM_CH       = 3,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int BANK_WIDTH   = 2,
  parameter int ARB_MODE     = 1,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                         Sys_clk,
  input  logic                         Rst,
  input  logic                         INIT_DONE,
  input  logic [3:0]                   COMMAND_INIT,
  input  logic [ADDR_WIDTH-1:0]        INIT_A_ADDR,
  input  logic [BANK_WIDTH-1:0]        INIT_BANK_ADDR,
  input  logic                         ARF_req,
  input  logic                         REF_DONE,
  input  logic [3:0]                   COMMAND_REF,
  input  logic [ADDR_WIDTH-1:0]        ARF_A_ADDR,
  input  logic [BANK_WIDTH-1:0]        ARF_BANK_ADDR,
  output logic                         ARF_access,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_done,
  input  logic [NUM_CH-1:0]            ch_break,
  input  logic [NUM_CH-1:0]            ch_dq_oe,
  input  logic [4*NUM_CH-1:0]          ch_cmd,
  input  logic [ADDR_WIDTH*NUM_CH-1:0] ch_a_addr,
  input  logic [BANK_WIDTH*NUM_CH-1:0] ch_bank,
  input  logic [DATA_WIDTH*NUM_CH-1:0] ch_wr_dq,
  output logic [NUM_CH-1:0]            ch_grant,
  output logic                         SDRAM_CS_N,
  output logic                         SDRAM_RAS_N,
  output logic                         SDRAM_CAS_N,
  output logic                         SDRAM_WE_N,
  output logic [ADDR_WIDTH-1:0]        SDRAM_A_ADDR,
  output logic [BANK_WIDTH-1:0]        SDRAM_BANK_ADDR,
  output logic [DATA_WIDTH-1:0]        SDRAM_DQ_O,
  output logic                         SDRAM_DQ_OE,
  input  logic [DATA_WIDTH-1:0]        SDRAM_DQ_I,
  output logic [DATA_WIDTH-1:0]        READ_SDRAM_DQ,
  output logic [NUM_CH-1:0]            active_ch,
  output logic                         busy
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ARB   = 3'd2,
    ST_ARF   = 3'd3,
    ST_SERVE = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   sel, rr_ptr, pick;
  logic               ch_win;
  logic               decide;
  logic [NUM_CH-1:0]  urgent;
  logic [3:0]         cmd;

  // Winner search: descending loops let the first match in search order win.
  always_comb begin
    pick   = '0;
    ch_win = 1'b0;
    if (ARB_MODE == 1) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (ch_req[(int'(rr_ptr) + 1 + k) % NUM_CH]) begin
          pick   = SEL_W'((int'(rr_ptr) + 1 + k) % NUM_CH);
          ch_win = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (ch_req[i]) begin
          pick   = SEL_W'(i);
          ch_win = 1'b1;
        end
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (urgent[i]) begin
        pick   = SEL_W'(i);
        ch_win = 1'b1;
      end
    end
  end

  assign decide     = (state == ST_ARB) && !Rst;
  assign ARF_access = decide && ARF_req;
  assign ch_grant   = (decide && !ARF_req && ch_win) ? (NUM_CH'(1) << pick) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_INIT;
      ST_INIT:  if (INIT_DONE) state_nxt = ST_ARB;
      ST_ARB: begin
        if (ARF_req)     state_nxt = ST_ARF;
        else if (ch_win) state_nxt = ST_SERVE;
      end
      ST_ARF:   if (REF_DONE) state_nxt = ST_ARB;
      ST_SERVE: if (ch_done[sel] || ch_break[sel]) state_nxt = ST_ARB;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Sys_clk) begin
    if (Rst) begin
      state         <= ST_IDLE;
      sel           <= '0;
      rr_ptr        <= SEL_W'(NUM_CH - 1);
      READ_SDRAM_DQ <= '0;
    end else begin
      state         <= state_nxt;
      READ_SDRAM_DQ <= SDRAM_DQ_I;
      if (|ch_grant) begin
        sel    <= pick;
        rr_ptr <= pick;
      end
    end
  end

  // Per-channel wait counters; the channel being served does not age.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_wait
    logic [CNT_W-1:0] cnt;
    logic             served;
    logic             aging;
    assign served = (state == ST_SERVE) && (sel == SEL_W'(i));
    assign aging  = (state == ST_ARB) || (state == ST_ARF) || (state == ST_SERVE);
    always_ff @(posedge Sys_clk) begin
      if (Rst || !ch_req[i] || ch_grant[i])
        cnt <= '0;
      else if (aging && !served && (cnt != CNT_MAX))
        cnt <= cnt + 1'b1;
    end
    assign urgent[i] = (STARVE_LIMIT != 0) && (cnt == CNT_MAX) && ch_req[i];
  end

  always_comb begin
    cmd             = CMD_NOP;
    SDRAM_A_ADDR    = '0;
    SDRAM_BANK_ADDR = '0;
    SDRAM_DQ_O      = '0;
    SDRAM_DQ_OE     = 1'b0;
    active_ch       = '0;
    case (state)
      ST_INIT: begin
        cmd             = COMMAND_INIT;
        SDRAM_A_ADDR    = INIT_A_ADDR;
        SDRAM_BANK_ADDR = INIT_BANK_ADDR;
      end
      ST_ARF: begin
        cmd             = COMMAND_REF;
        SDRAM_A_ADDR    = ARF_A_ADDR;
        SDRAM_BANK_ADDR = ARF_BANK_ADDR;
      end
      ST_SERVE: begin
        cmd             = ch_cmd[sel*4 +: 4];
        SDRAM_A_ADDR    = ch_a_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        SDRAM_BANK_ADDR = ch_bank[sel*BANK_WIDTH +: BANK_WIDTH];
        SDRAM_DQ_O      = ch_wr_dq[sel*DATA_WIDTH +: DATA_WIDTH];
        SDRAM_DQ_OE     = ch_dq_oe[sel];
        active_ch       = NUM_CH'(1) << sel;
      end
      default: ;
    endcase
  end

  assign {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N} = cmd;
  assign busy = (state != ST_ARB);

endmodule
`default_nettype wire
